// File: rtl/gate_scanner.sv
// Layer gate sequencer: walks every gate of one layer, queries the add/mul wiring
// lookups, and streams one record per wired gate over a valid/ready handshake.
module gate_scanner #(
    parameter int LN_LAYER = 1,
    parameter int G        = 3,
    parameter int NUM_BITS = 3,
    parameter int LN_G     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LN_LAYER:0]   layer,
    output logic [LN_G:0]       currGate,
    output logic [LN_LAYER:0]   currLayer,
    input  logic [NUM_BITS:0]   addConnGate,
    input  logic                isAdd,
    input  logic [NUM_BITS:0]   mulConnGate,
    input  logic                isMul,
    output logic                outValid,
    input  logic                outReady,
    output logic [LN_G:0]       outGate,
    output logic [NUM_BITS:0]   outConnGate,
    output logic                outIsMul,
    output logic [LN_G+1:0]     addCount,
    output logic [LN_G+1:0]     mulCount,
    output logic                busy,
    output logic                done,
    output logic                conflict
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [LN_G:0] LAST_GATE = (LN_G+1)'(G - 1);

    state_t              r_state;
    state_t              w_next;
    logic [LN_G:0]       r_curr_gate;
    logic [LN_LAYER:0]   r_curr_layer;
    logic [LN_G:0]       r_out_gate;
    logic [NUM_BITS:0]   r_out_conn;
    logic                r_out_is_mul;
    logic [LN_G+1:0]     r_add_count;
    logic [LN_G+1:0]     r_mul_count;
    logic                r_conflict;

    logic w_last;
    logic w_accept;
    logic w_cap_add;
    logic w_cap_mul;
    logic w_step;
    logic w_hit_conflict;

    assign w_last = (r_curr_gate == LAST_GATE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_cap_add      = 1'b0;
        w_cap_mul      = 1'b0;
        w_step         = 1'b0;
        w_hit_conflict = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (isAdd && !isMul) begin
                    w_cap_add = 1'b1;
                    w_next    = S_EMIT;
                end else if (isMul && !isAdd) begin
                    w_cap_mul = 1'b1;
                    w_next    = S_EMIT;
                end else begin
                    // unwired or doubly-wired gate: no record, one cycle only
                    w_hit_conflict = isAdd && isMul;
                    if (w_last) w_next = S_DONE;
                    else        w_step = 1'b1;
                end
            end
            S_EMIT: begin
                if (outReady) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_step = 1'b1;
                        w_next = S_SCAN;
                    end
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_curr_gate  <= '0;
            r_curr_layer <= '0;
            r_out_gate   <= '0;
            r_out_conn   <= '0;
            r_out_is_mul <= 1'b0;
            r_add_count  <= '0;
            r_mul_count  <= '0;
            r_conflict   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_curr_layer <= layer;
                r_curr_gate  <= '0;
                r_add_count  <= '0;
                r_mul_count  <= '0;
                r_conflict   <= 1'b0;
            end
            if (w_step) r_curr_gate <= r_curr_gate + 1'b1;
            if (w_cap_add) begin
                r_out_gate   <= r_curr_gate;
                r_out_conn   <= addConnGate;
                r_out_is_mul <= 1'b0;
                r_add_count  <= r_add_count + 1'b1;
            end
            if (w_cap_mul) begin
                r_out_gate   <= r_curr_gate;
                r_out_conn   <= mulConnGate;
                r_out_is_mul <= 1'b1;
                r_mul_count  <= r_mul_count + 1'b1;
            end
            if (w_hit_conflict) r_conflict <= 1'b1;
        end
    end

    assign currGate    = r_curr_gate;
    assign currLayer   = r_curr_layer;
    assign outGate     = r_out_gate;
    assign outConnGate = r_out_conn;
    assign outIsMul    = r_out_is_mul;
    assign addCount    = r_add_count;
    assign mulCount    = r_mul_count;
    assign conflict    = r_conflict;
    // decoded straight from the state register so valid never depends on outReady
    assign outValid    = (r_state == S_EMIT);
    assign busy        = (r_state == S_SCAN) || (r_state == S_EMIT);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_gate_scanner.sv
// Scoreboard bench for gate_scanner: a table-driven wiring stub feeds the lookups,
// expected records are queued per scan and popped on each output handshake.
module tb_gate_scanner;

    logic       clk = 1'b0;
    logic       rst, start, outReady;
    logic [1:0] layer;
    logic [1:0] currGate, currLayer, outGate;
    logic [3:0] addConnGate, mulConnGate, outConnGate;
    logic       isAdd, isMul, outValid, outIsMul, busy, done, conflict;
    logic [2:0] addCount, mulCount;

    always #5 clk = ~clk;

    gate_scanner dut (
        .clk(clk), .rst(rst), .start(start), .layer(layer),
        .currGate(currGate), .currLayer(currLayer),
        .addConnGate(addConnGate), .isAdd(isAdd),
        .mulConnGate(mulConnGate), .isMul(isMul),
        .outValid(outValid), .outReady(outReady),
        .outGate(outGate), .outConnGate(outConnGate), .outIsMul(outIsMul),
        .addCount(addCount), .mulCount(mulCount),
        .busy(busy), .done(done), .conflict(conflict)
    );

    // wiring stub tables, indexed by currGate
    logic       t_add [4];
    logic       t_mul [4];
    logic [3:0] t_ac  [4];
    logic [3:0] t_mc  [4];

    always_comb begin
        isAdd       = t_add[currGate];
        isMul       = t_mul[currGate];
        addConnGate = t_ac[currGate];
        mulConnGate = t_mc[currGate];
    end

    typedef struct {
        logic [1:0] gate;
        logic [3:0] conn;
        logic       mul;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_seen++;
        if (!rst && outValid && outReady) begin
            chk("sb_avail", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                rec_t e;
                e = sb.pop_front();
                chk("rec_gate", 32'(outGate), 32'(e.gate));
                chk("rec_conn", 32'(outConnGate), 32'(e.conn));
                chk("rec_mul", 32'(outIsMul), 32'(e.mul));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tab(input logic [2:0] a, input logic [2:0] m);
        for (int g = 0; g < 4; g++) begin
            t_add[g] = (g < 3) ? a[g] : 1'b0;
            t_mul[g] = (g < 3) ? m[g] : 1'b0;
        end
        t_ac[0] = 4'd5; t_ac[1] = 4'd9; t_ac[2] = 4'd7; t_ac[3] = 4'd0;
        t_mc[0] = 4'd11; t_mc[1] = 4'd2; t_mc[2] = 4'd13; t_mc[3] = 4'd0;
    endtask

    // Runs one full scan; expected records, counts and latency come from the stub tables.
    task automatic run_scan(input logic [1:0] lay, input bit stall_en, input bit busy_start);
        int   ea = 0, em = 0, econf = 0, elat = 1, k = 1, stalls = 0, held = 0;
        bool_wired: begin end
        for (int g = 0; g < 3; g++) begin
            rec_t r;
            r.gate = 2'(g);
            if (t_add[g] && !t_mul[g]) begin
                r.conn = t_ac[g]; r.mul = 1'b0; sb.push_back(r); ea++; elat += 2;
            end else if (t_mul[g] && !t_add[g]) begin
                r.conn = t_mc[g]; r.mul = 1'b1; sb.push_back(r); em++; elat += 1 + 1;
            end else begin
                if (t_add[g] && t_mul[g]) econf = 1;
                elat += 1;
            end
        end
        if (stall_en) elat += 4;
        outReady = 1'b1;
        layer    = lay;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("scan_conf_clr", 32'(conflict), 0);
        while (!done && k < 40) begin
            if (busy_start) begin
                start = (k == 2);
                layer = (k == 2) ? 2'd3 : lay;
            end
            chk("cur_layer", 32'(currLayer), 32'(lay));
            if (outValid && outGate == 2'd1) begin
                held++;
                if (stall_en) begin
                    chk("hold_conn", 32'(outConnGate), 32'(t_mc[1]));
                    chk("hold_mul", 32'(outIsMul), 1);
                end
            end
            if (stall_en && outValid && outGate == 2'd1 && stalls < 4) begin
                outReady = 1'b0;
                stalls++;
            end else begin
                outReady = 1'b1;
            end
            step();
            k++;
        end
        start = 1'b0;
        chk("done_lat", 32'(k), 32'(elat));
        chk("add_cnt", 32'(addCount), 32'(ea));
        chk("mul_cnt", 32'(mulCount), 32'(em));
        chk("conflict", 32'(conflict), 32'(econf));
        chk("busy_in_done", 32'(busy), 0);
        chk("layer_at_done", 32'(currLayer), 32'(lay));
        if (stall_en) chk("held_cycles", 32'(held), 5);
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("sb_drain", 32'(sb.size()), 0);
        chk("cnt_hold", 32'(addCount), 32'(ea));
    endtask

    initial begin
        int d0, k;
        rec_t r;
        rst = 1'b1; start = 1'b0; layer = 2'd0; outReady = 1'b1;
        set_tab(3'b101, 3'b010);
        step(); step();
        chk("rst_gate", 32'(currGate), 0);
        chk("rst_layer", 32'(currLayer), 0);
        chk("rst_valid", 32'(outValid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'({addCount, mulCount}), 0);
        chk("rst_rec", 32'({outGate, outConnGate, outIsMul}), 0);
        chk("rst_conf", 32'(conflict), 0);
        rst = 1'b0;
        step();

        // all wired: add, mul, add
        run_scan(2'd2, 1'b0, 1'b0);
        // consumer stalls 4 cycles on record 1
        run_scan(2'd1, 1'b1, 1'b0);
        // gate1 unwired
        set_tab(3'b101, 3'b000);
        run_scan(2'd0, 1'b0, 1'b0);
        // gate2 doubly wired
        set_tab(3'b101, 3'b110);
        run_scan(2'd2, 1'b0, 1'b0);
        // conflict clears on next start; stray start while busy ignored
        set_tab(3'b101, 3'b010);
        run_scan(2'd1, 1'b0, 1'b1);

        // reset during EMIT of gate1
        r.gate = 2'd0; r.conn = 4'd5; r.mul = 1'b0;
        sb.push_back(r);
        layer = 2'd2; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(outValid && outGate == 2'd1) && k < 20) begin
            step();
            k++;
        end
        chk("reach_emit1", 32'(k < 20), 1);
        outReady = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(outValid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cnt", 32'({addCount, mulCount}), 0);
        chk("mid_rst_gate", 32'(currGate), 0);
        rst = 1'b0;
        d0 = done_seen;
        step(); step(); step();
        chk("mid_rst_nodone", 32'(done_seen), 32'(d0));
        chk("mid_rst_sb", 32'(sb.size()), 0);
        run_scan(2'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
